// File: rtl/sub32_serial_if.sv
// Handshake and operand/result bundle for the digit-serial subtractor.
// The sat_mode signal exists only when SUB32_SERIAL_SATURATE_EN is defined.
interface sub32_serial_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         b_in;
  logic         o_valid;
  logic         o_ready;
  logic [N-1:0] d;
  logic         b_out;
  logic         v_out;
`ifdef SUB32_SERIAL_SATURATE_EN
  logic         sat_mode;

  modport master (
    output i_valid, a, b, b_in, sat_mode, o_ready,
    input  i_ready, o_valid, d, b_out, v_out
  );

  modport slave (
    input  i_valid, a, b, b_in, sat_mode, o_ready,
    output i_ready, o_valid, d, b_out, v_out
  );
`else
  modport master (
    output i_valid, a, b, b_in, o_ready,
    input  i_ready, o_valid, d, b_out, v_out
  );

  modport slave (
    input  i_valid, a, b, b_in, o_ready,
    output i_ready, o_valid, d, b_out, v_out
  );
`endif
endinterface

// File: rtl/sub32_serial.sv
// Digit-serial subtractor d = a - b - b_in, DIGIT_W bits per clock, LSD first.
// Optional saturation enabled by defining SUB32_SERIAL_SATURATE_EN.
module sub32_serial #(
  parameter int N       = 32,
  parameter int DIGIT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  sub32_serial_if.slave  bus
);

  localparam int NDIG  = N / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if ((N % DIGIT_W) != 0) begin : g_width_chk
    $error("sub32_serial: N must be an integer multiple of DIGIT_W");
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     a_sh;
  logic [N-1:0]     b_sh;
  logic [N-1:0]     d_sh;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic [N-1:0]     d_r;
  logic             b_out_r;
  logic             v_out_r;

  logic [DIGIT_W:0] diff;
  logic [N-1:0]     d_sh_nxt;
  logic             v_nxt;
  logic [N-1:0]     d_fin;

`ifdef SUB32_SERIAL_SATURATE_EN
  logic sat_q;

  function automatic logic [N-1:0] saturate(input logic [N-1:0] raw, input logic brw,
                                            input logic ovf, input logic mode,
                                            input logic neg);
    if (!mode) return brw ? '0 : raw;
    if (ovf)   return neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    return raw;
  endfunction
`endif

  // Extra top bit of the digit subtract carries the digit borrow.
  always_comb begin
    diff     = {1'b0, a_sh[DIGIT_W-1:0]} - {1'b0, b_sh[DIGIT_W-1:0]}
             - {{DIGIT_W{1'b0}}, borrow};
    d_sh_nxt = (d_sh >> DIGIT_W) | (N'(diff[DIGIT_W-1:0]) << (N - DIGIT_W));
    v_nxt    = (a_msb != b_msb) && (d_sh_nxt[N-1] != a_msb);
`ifdef SUB32_SERIAL_SATURATE_EN
    d_fin    = saturate(d_sh_nxt, diff[DIGIT_W], v_nxt, sat_q, a_msb);
`else
    d_fin    = d_sh_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      d_sh    <= '0;
      borrow  <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      d_r     <= '0;
      b_out_r <= 1'b0;
      v_out_r <= 1'b0;
`ifdef SUB32_SERIAL_SATURATE_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            borrow <= bus.b_in;
            a_msb  <= bus.a[N-1];
            b_msb  <= bus.b[N-1];
            cnt    <= '0;
`ifdef SUB32_SERIAL_SATURATE_EN
            sat_q  <= bus.sat_mode;
`endif
            state  <= BUSY;
          end
        end
        BUSY: begin
          a_sh   <= a_sh >> DIGIT_W;
          b_sh   <= b_sh >> DIGIT_W;
          d_sh   <= d_sh_nxt;
          borrow <= diff[DIGIT_W];
          cnt    <= cnt + 1'b1;
          // Last digit: publish the result so outputs change only on completion.
          if (cnt == LAST) begin
            d_r     <= d_fin;
            b_out_r <= diff[DIGIT_W];
            v_out_r <= v_nxt;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.o_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.i_ready = (state == IDLE);
  assign bus.o_valid = (state == DONE);
  assign bus.d       = d_r;
  assign bus.b_out   = b_out_r;
  assign bus.v_out   = v_out_r;

endmodule
